// File: rtl/q_max_select.sv
// Q-row max scanner: reads one action per cycle from the Q-table, returns the greedy
// max Q and the chosen action, with an LFSR-driven epsilon-greedy override.
module q_max_select #(
    parameter int unsigned N_STATES   = 36,
    parameter int unsigned N_ACTIONS  = 4,
    parameter int unsigned DATA_W     = 32,
    parameter logic [7:0]  EPS_THRESH = 8'd26,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        state,
    output logic              busy,
    output logic              done,
    output logic              q_rd_en,
    output logic [5:0]        q_rd_state,
    output logic [2:0]        q_rd_action,
    input  logic [DATA_W-1:0] q_rd_data,
    output logic [DATA_W-1:0] max_Q,
    output logic [2:0]        action,
    output logic              explored
);

    localparam int unsigned AW       = $clog2(N_ACTIONS);
    localparam logic [2:0]  LAST_ACT = 3'(N_ACTIONS - 1);
    localparam logic [6:0]  N_ST     = 7'(N_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t              fsm;
    logic [7:0]        lfsr;
    logic [7:0]        lfsr_lat;
    logic              data_vld;
    logic [2:0]        data_idx;
    logic [DATA_W-1:0] best;
    logic [2:0]        best_idx;

    logic              lfsr_fb;
    logic              take;
    logic [DATA_W-1:0] nxt_best;
    logic [2:0]        nxt_idx;
    logic              state_ok;

    // Running maximum: first datum always loads, later ones only when strictly greater.
    always_comb begin
        lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        state_ok = ({1'b0, state} < N_ST);
        take     = data_vld && ((data_idx == 3'd0) || ($signed(q_rd_data) > $signed(best)));
        nxt_best = take ? q_rd_data : best;
        nxt_idx  = take ? data_idx : best_idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm         <= IDLE;
            lfsr        <= LFSR_SEED;
            lfsr_lat    <= 8'd0;
            data_vld    <= 1'b0;
            data_idx    <= 3'd0;
            best        <= '0;
            best_idx    <= 3'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            q_rd_en     <= 1'b0;
            q_rd_state  <= 6'd0;
            q_rd_action <= 3'd0;
            max_Q       <= '0;
            action      <= 3'd0;
            explored    <= 1'b0;
        end else begin
            lfsr     <= {lfsr[6:0], lfsr_fb};
            done     <= 1'b0;
            data_vld <= q_rd_en;
            data_idx <= q_rd_action;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        if (state_ok) begin
                            fsm         <= SCAN;
                            busy        <= 1'b1;
                            q_rd_en     <= 1'b1;
                            q_rd_state  <= state;
                            q_rd_action <= 3'd0;
                            lfsr_lat    <= lfsr;
                        end else begin
                            // Out-of-range state: finish immediately with a zeroed result.
                            fsm      <= DONE;
                            done     <= 1'b1;
                            max_Q    <= '0;
                            action   <= 3'd0;
                            explored <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    if (q_rd_en) begin
                        if (q_rd_action == LAST_ACT) begin
                            q_rd_en     <= 1'b0;
                            q_rd_action <= 3'd0;
                        end else begin
                            q_rd_action <= q_rd_action + 3'd1;
                        end
                    end
                    if (data_vld) begin
                        best     <= nxt_best;
                        best_idx <= nxt_idx;
                        if (data_idx == LAST_ACT) begin
                            fsm        <= DONE;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            q_rd_state <= 6'd0;
                            max_Q      <= nxt_best;
                            if (lfsr_lat < EPS_THRESH) begin
                                action   <= 3'(lfsr_lat[AW-1:0]);
                                explored <= 1'b1;
                            end else begin
                                action   <= nxt_idx;
                                explored <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    fsm <= IDLE;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q_max_select.sv
// Bench for q_max_select: three instances (EPS 0, 26, 255) on shared stimulus, checked
// every cycle against a transaction-level model, plus hand-computed literal results.
module tb_q_max_select;

    localparam int unsigned NA = 4;
    localparam int unsigned NS = 36;
    localparam logic [23:0] EPS_TAB = {8'd255, 8'd26, 8'd0};
    localparam logic [7:0]  SEED = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] state = 6'd0;

    logic        busy_v [3];
    logic        done_v [3];
    logic        en_v   [3];
    logic        expl_v [3];
    logic [5:0]  st_v   [3];
    logic [2:0]  ract_v [3];
    logic [2:0]  act_v  [3];
    logic [31:0] rdata_v[3];
    logic [31:0] max_v  [3];

    logic [31:0] qmem [64][4];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        q_max_select #(
            .N_STATES(NS), .N_ACTIONS(NA), .DATA_W(32),
            .EPS_THRESH(EPS_TAB[g*8 +: 8]), .LFSR_SEED(SEED)
        ) dut (
            .clk(clk), .rst(rst), .start(start), .state(state),
            .busy(busy_v[g]), .done(done_v[g]), .q_rd_en(en_v[g]),
            .q_rd_state(st_v[g]), .q_rd_action(ract_v[g]), .q_rd_data(rdata_v[g]),
            .max_Q(max_v[g]), .action(act_v[g]), .explored(expl_v[g])
        );
        // Q-table storage with one cycle of read latency
        always @(posedge clk) if (en_v[g]) rdata_v[g] <= qmem[st_v[g]][ract_v[g][1:0]];
    end

    task automatic chk(input string nm, input int g, input logic [31:0] got, input logic [31:0] req);
        n_chk++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s inst=%0d t=%0t got=%h req=%h", nm, g, $time, got, req);
        end
    endtask

    function automatic logic [7:0] lstep(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Transaction-level model: times everything relative to the accepting edge t0.
    int          m_k = 0, m_t0 = -100, m_free = 0;
    bit          m_tv = 0;
    logic [5:0]  m_s = 0;
    logic [7:0]  m_lfsr = SEED, m_lat = 0, pre;
    logic [31:0] p_max = 0, m_max = 0;
    logic [2:0]  p_act [3];
    logic        p_expl[3];
    logic [2:0]  e_action[3];
    logic        e_expl[3];
    logic        e_busy = 0, e_done = 0, e_en = 0;
    logic [5:0]  e_st = 0;
    logic [2:0]  e_ract = 0;

    initial begin
        for (int g = 0; g < 3; g++) begin
            p_act[g] = 0; p_expl[g] = 0; e_action[g] = 0; e_expl[g] = 0;
        end
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_lfsr = SEED; m_k = 0; m_free = 0; m_t0 = -100; m_tv = 0; m_max = 0;
                for (int g = 0; g < 3; g++) begin e_action[g] = 0; e_expl[g] = 0; end
            end else begin
                pre = m_lfsr;
                m_lfsr = lstep(m_lfsr);
                m_k++;
                if (start && m_k >= m_free) begin
                    m_t0 = m_k; m_s = state; m_lat = pre;
                    m_tv = (int'(state) < NS);
                    if (m_tv) begin
                        int best_i;
                        int mx;
                        mx = $signed(qmem[state][0]);
                        for (int a = 1; a < NA; a++)
                            if ($signed(qmem[state][a]) > mx) mx = $signed(qmem[state][a]);
                        best_i = NA;
                        for (int a = NA - 1; a >= 0; a--)
                            if ($signed(qmem[state][a]) == mx) best_i = a;
                        p_max = 32'(mx);
                        for (int g = 0; g < 3; g++) begin
                            if (pre < EPS_TAB[g*8 +: 8]) begin
                                p_act[g] = 3'(pre % 8'(NA)); p_expl[g] = 1;
                            end else begin
                                p_act[g] = 3'(best_i); p_expl[g] = 0;
                            end
                        end
                        m_free = m_k + NA + 3;
                    end else begin
                        p_max = 0;
                        for (int g = 0; g < 3; g++) begin p_act[g] = 0; p_expl[g] = 0; end
                        m_free = m_k + 2;
                    end
                end
                if (m_k == m_t0 + (m_tv ? NA + 1 : 0)) begin
                    m_max = p_max;
                    for (int g = 0; g < 3; g++) begin e_action[g] = p_act[g]; e_expl[g] = p_expl[g]; end
                end
            end
            e_en   = m_tv && m_k >= m_t0 && m_k <= m_t0 + NA - 1;
            e_busy = m_tv && m_k >= m_t0 && m_k <= m_t0 + NA;
            e_done = (m_k == m_t0 + (m_tv ? NA + 1 : 0));
            e_ract = e_en ? 3'(m_k - m_t0) : 3'd0;
            e_st   = e_busy ? m_s : 6'd0;
        end
    end

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("busy", g, 32'(busy_v[g]), 32'(e_busy));
            chk("done", g, 32'(done_v[g]), 32'(e_done));
            chk("q_rd_en", g, 32'(en_v[g]), 32'(e_en));
            chk("q_rd_state", g, 32'(st_v[g]), 32'(e_st));
            chk("q_rd_action", g, 32'(ract_v[g]), 32'(e_ract));
            chk("max_Q", g, max_v[g], m_max);
            chk("action", g, 32'(act_v[g]), 32'(e_action[g]));
            chk("explored", g, 32'(expl_v[g]), 32'(e_expl[g]));
        end
    end

    task automatic set_row(input int s, input logic [31:0] a0, a1, a2, a3);
        qmem[s][0] = a0; qmem[s][1] = a1; qmem[s][2] = a2; qmem[s][3] = a3;
    endtask

    task automatic run_txn(input logic [5:0] s, input bit extra,
                           output int cyc, output int en_cnt, output int dn_cnt);
        cyc = 0; en_cnt = 0; dn_cnt = 0;
        @(negedge clk);
        start = 1'b1; state = s;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            start = extra && (c == 2 || c == 4);
            state = 6'($urandom);
            if (en_v[0]) en_cnt++;
            if (done_v[0]) begin
                dn_cnt++;
                if (cyc == 0) cyc = c;
            end
            if (cyc != 0 && c >= cyc + 2) break;
        end
        start = 1'b0;
        n_chk++;
        if (cyc == 0) begin
            n_fail++;
            $display("FAIL done_timeout state=%0d got=none req=pulse", s);
        end
    endtask

    initial begin
        int cyc, en_cnt, dn_cnt;
        logic [5:0] s;
        bit extra;
        for (int r = 0; r < 64; r++)
            for (int a = 0; a < 4; a++) qmem[r][a] = $urandom;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 0, 32'(busy_v[0]), 32'd0);
        chk("rst_max", 0, max_v[0], 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Tie: lowest index wins; also pins timing and the EPS=255 override
        set_row(5, 32'h00010000, 32'h00038000, 32'hFFFE0000, 32'h00038000);
        run_txn(6'd5, 1'b0, cyc, en_cnt, dn_cnt);
        chk("t1_cycle", 0, 32'(cyc), 32'd6);
        chk("t1_max", 0, max_v[0], 32'h00038000);
        chk("t1_action", 0, 32'(act_v[0]), 32'd1);
        chk("t1_expl", 0, 32'(expl_v[0]), 32'd0);
        chk("t4_expl", 2, 32'(expl_v[2]), 32'(m_lat != 8'hFF));
        chk("t4_max", 2, max_v[2], 32'h00038000);

        // Signed compare
        set_row(9, 32'hFFFF0000, 32'hFFFC0000, 32'hFFFF8000, 32'hFFFD0000);
        run_txn(6'd9, 1'b0, cyc, en_cnt, dn_cnt);
        chk("t2_max", 0, max_v[0], 32'hFFFF8000);
        chk("t2_action", 0, 32'(act_v[0]), 32'd2);

        // Extra start pulses during a scan are ignored
        set_row(3, 32'h00000005, 32'h00000009, 32'h00000001, 32'h00000002);
        run_txn(6'd3, 1'b1, cyc, en_cnt, dn_cnt);
        chk("t3_rd_cycles", 0, 32'(en_cnt), 32'd4);
        chk("t3_done_cnt", 0, 32'(dn_cnt), 32'd1);
        chk("t3_action", 0, 32'(act_v[0]), 32'd1);

        // Reset mid-scan aborts without a done pulse
        set_row(7, 32'h00020000, 32'h00050000, 32'h00050000, 32'hFFFF0000);
        @(negedge clk); start = 1'b1; state = 6'd7;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("t5_busy", 0, 32'(busy_v[0]), 32'd0);
        chk("t5_rd_en", 0, 32'(en_v[0]), 32'd0);
        chk("t5_max", 0, max_v[0], 32'd0);
        chk("t5_done", 0, 32'(done_v[0]), 32'd0);
        @(negedge clk); rst = 1'b1;
        run_txn(6'd7, 1'b0, cyc, en_cnt, dn_cnt);
        chk("t5_cycle", 0, 32'(cyc), 32'd6);
        chk("t5_max2", 0, max_v[0], 32'h00050000);
        chk("t5_action2", 0, 32'(act_v[0]), 32'd1);

        // Invalid state
        run_txn(6'd40, 1'b0, cyc, en_cnt, dn_cnt);
        chk("t6_cycle", 0, 32'(cyc), 32'd1);
        chk("t6_rd_cycles", 0, 32'(en_cnt), 32'd0);
        chk("t6_max", 0, max_v[0], 32'd0);
        chk("t6_action", 0, 32'(act_v[0]), 32'd0);

        // Randomized transactions, ties likely from a small value set
        for (int i = 0; i < 80; i++) begin
            s = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(36, 63)) : 6'($urandom_range(0, 35));
            for (int a = 0; a < 4; a++)
                qmem[s][a] = ($urandom_range(0, 1) == 0) ? $urandom
                           : 32'($signed(32'($urandom_range(0, 4)) - 32'd2) <<< 16);
            extra = (int'(s) < NS) && ($urandom_range(0, 1) == 1);
            run_txn(s, extra, cyc, en_cnt, dn_cnt);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
